// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared constants and types for the two-requester on-chip RAM arbiter.
package onchip_mem_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;
    localparam int MEM_WORDS  = 4096;
    localparam int REQ_CNT    = 2;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t owner;
    } lock_state_t;

    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM bundle: two requester ports plus the RAM-side port of the arbiter.
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
) ();

    logic [ADDR_W-1:0] r0_address;
    logic [BE_W-1:0]   r0_byteenable;
    logic              r0_read;
    logic              r0_write;
    logic [DATA_W-1:0] r0_writedata;
    logic              r0_lock;
    logic              r0_waitrequest;
    logic [DATA_W-1:0] r0_readdata;
    logic              r0_readdatavalid;

    logic [ADDR_W-1:0] r1_address;
    logic [BE_W-1:0]   r1_byteenable;
    logic              r1_read;
    logic              r1_write;
    logic [DATA_W-1:0] r1_writedata;
    logic              r1_lock;
    logic              r1_waitrequest;
    logic [DATA_W-1:0] r1_readdata;
    logic              r1_readdatavalid;

    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    modport slave (
        input  r0_address, r0_byteenable, r0_read, r0_write, r0_writedata, r0_lock,
        output r0_waitrequest, r0_readdata, r0_readdatavalid,
        input  r1_address, r1_byteenable, r1_read, r1_write, r1_writedata, r1_lock,
        output r1_waitrequest, r1_readdata, r1_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
        input  mem_readdata
    );

    modport master (
        output r0_address, r0_byteenable, r0_read, r0_write, r0_writedata, r0_lock,
        input  r0_waitrequest, r0_readdata, r0_readdatavalid,
        output r1_address, r1_byteenable, r1_read, r1_write, r1_writedata, r1_lock,
        input  r1_waitrequest, r1_readdata, r1_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
        output mem_readdata
    );

endinterface

// File: rtl/onchip_mem_arbiter_rr_grant2.sv
// Combinational two-way round-robin grant with a bounded lock override.
module rr_grant2
    import onchip_mem_pkg::*;
#(
    parameter int MAX_LOCK = 16,
    parameter int CNT_W    = 5
) (
    input  logic [1:0]       req_i,
    input  req_id_t          last_grant_i,
    input  lock_state_t      lock_i,
    input  logic [CNT_W-1:0] lock_cnt_i,
    output logic [1:0]       grant_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

    req_id_t lock_other;
    logic    lock_win;

    assign lock_other = other_req(lock_i.owner);

    // The owner keeps the RAM unless it has starved a waiting peer for MAX_LOCK grants.
    assign lock_win = lock_i.valid && req_i[lock_i.owner]
                      && !((lock_cnt_i == MAX_CNT) && req_i[lock_other]);

    always_comb begin
        grant_o = 2'b00;
        if (lock_win) begin
            grant_o[lock_i.owner] = 1'b1;
        end else if (&req_i) begin
            grant_o[other_req(last_grant_i)] = 1'b1;
        end else begin
            grant_o = req_i;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one synchronous single-port RAM between two Avalon-MM requesters with
// round-robin fairness, bounded locking and 1-cycle read-data routing.
module onchip_mem_arbiter
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BE_W     = DATA_W / 8,
    parameter int MAX_LOCK = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    onchip_mem_arbiter_if.slave  bus
);

    localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

    logic [REQ_CNT-1:0] req;
    logic [REQ_CNT-1:0] wr;
    logic [REQ_CNT-1:0] lock_req;
    logic [REQ_CNT-1:0] grant;
    logic [REQ_CNT-1:0] wait_req;
    logic [REQ_CNT-1:0] rd_valid;
    logic [ADDR_W-1:0]  addr  [REQ_CNT];
    logic [BE_W-1:0]    be    [REQ_CNT];
    logic [DATA_W-1:0]  wdata [REQ_CNT];

    req_id_t            winner;
    req_id_t            loser;
    logic               gnt_any;

    req_id_t            last_grant_q, last_grant_d;
    lock_state_t        lock_q, lock_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0]   cnt_base;
    logic               rd_pend_q, rd_pend_d;
    req_id_t            rd_owner_q, rd_owner_d;

    // A simultaneous read+write counts as a write, so write alone selects the RAM op.
    assign req[0]      = bus.r0_read | bus.r0_write;
    assign req[1]      = bus.r1_read | bus.r1_write;
    assign wr[0]       = bus.r0_write;
    assign wr[1]       = bus.r1_write;
    assign lock_req[0] = bus.r0_lock;
    assign lock_req[1] = bus.r1_lock;
    assign addr[0]     = bus.r0_address;
    assign addr[1]     = bus.r1_address;
    assign be[0]       = bus.r0_byteenable;
    assign be[1]       = bus.r1_byteenable;
    assign wdata[0]    = bus.r0_writedata;
    assign wdata[1]    = bus.r1_writedata;

    rr_grant2 #(
        .MAX_LOCK (MAX_LOCK),
        .CNT_W    (CNT_W)
    ) u_grant (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .lock_i       (lock_q),
        .lock_cnt_i   (lock_cnt_q),
        .grant_o      (grant)
    );

    assign winner  = grant[1];
    assign loser   = other_req(winner);
    assign gnt_any = |grant;

    generate
        for (genvar gi = 0; gi < REQ_CNT; gi++) begin : g_port
            assign wait_req[gi] = reset | ~grant[gi];
            assign rd_valid[gi] = rd_pend_q & (rd_owner_q == req_id_t'(gi));
        end
    endgenerate

    assign bus.r0_waitrequest   = wait_req[0];
    assign bus.r1_waitrequest   = wait_req[1];
    assign bus.r0_readdatavalid = rd_valid[0];
    assign bus.r1_readdatavalid = rd_valid[1];
    assign bus.r0_readdata      = bus.mem_readdata;
    assign bus.r1_readdata      = bus.mem_readdata;

    assign bus.mem_chipselect = ~reset & gnt_any;
    assign bus.mem_write      = ~reset & gnt_any & wr[winner];
    assign bus.mem_address    = addr[winner];
    assign bus.mem_byteenable = be[winner];
    assign bus.mem_writedata  = wdata[winner];
    assign bus.mem_clken      = 1'b1;

    always_comb begin
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        lock_cnt_d   = lock_cnt_q;
        cnt_base     = '0;
        rd_pend_d    = 1'b0;
        rd_owner_d   = rd_owner_q;

        if (gnt_any) begin
            last_grant_d = winner;
            if (!wr[winner]) begin
                rd_pend_d  = 1'b1;
                rd_owner_d = winner;
            end
            // The count covers every locked grant taken while the peer waits,
            // including the grant that establishes a new owner.
            if (lock_req[winner]) begin
                cnt_base     = (lock_q.valid && (lock_q.owner == winner)) ? lock_cnt_q : '0;
                lock_d.valid = 1'b1;
                lock_d.owner = winner;
                lock_cnt_d   = (req[loser] && (cnt_base != MAX_CNT)) ? cnt_base + CNT_W'(1)
                                                                     : cnt_base;
            end else begin
                lock_d.valid = 1'b0;
                lock_cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            lock_q       <= '0;
            lock_cnt_q   <= '0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Randomised scoreboard bench for onchip_mem_arbiter with a behavioural RAM and
// an arbitration/memory reference model.
module tb_onchip_mem_arbiter;
    import onchip_mem_pkg::*;

    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int MAXL = 16;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic        lock;
        int          gap;
    } cmd_t;

    typedef struct {
        int          owner;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) bus ();

    onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .MAX_LOCK(MAXL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Behavioural synchronous RAM
    logic [DW-1:0] ram [0:MEM_WORDS-1];
    logic [DW-1:0] ram_q;
    assign bus.mem_readdata = ram_q;
    always @(posedge clk) begin
        if (bus.mem_clken && bus.mem_chipselect) begin
            if (bus.mem_write) begin
                for (int b = 0; b < BW; b++)
                    if (bus.mem_byteenable[b]) ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
            end else begin
                ram_q <= ram[bus.mem_address];
            end
        end
    end

    // Requester drivers
    cmd_t        cq0[$];
    cmd_t        cq1[$];
    cmd_t        cur [2];
    logic [1:0]  busy = 2'b00;
    int          wcnt [2];
    logic [1:0]  acc = 2'b00;
    logic [1:0]  d_rd = 2'b00, d_wr = 2'b00, d_lock = 2'b00;
    logic [11:0] d_addr [2];
    logic [3:0]  d_be [2];
    logic [31:0] d_data [2];

    assign bus.r0_read = d_rd[0];       assign bus.r1_read = d_rd[1];
    assign bus.r0_write = d_wr[0];      assign bus.r1_write = d_wr[1];
    assign bus.r0_lock = d_lock[0];     assign bus.r1_lock = d_lock[1];
    assign bus.r0_address = d_addr[0];  assign bus.r1_address = d_addr[1];
    assign bus.r0_byteenable = d_be[0]; assign bus.r1_byteenable = d_be[1];
    assign bus.r0_writedata = d_data[0]; assign bus.r1_writedata = d_data[1];

    initial begin
        for (int i = 0; i < 2; i++) begin
            d_addr[i] = '0; d_be[i] = '0; d_data[i] = '0; wcnt[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (busy[i] && acc[i]) busy[i] = 1'b0;
                if (!busy[i]) begin
                    if (i == 0 && cq0.size() > 0) begin
                        cur[i] = cq0.pop_front(); busy[i] = 1'b1; wcnt[i] = cur[i].gap;
                    end else if (i == 1 && cq1.size() > 0) begin
                        cur[i] = cq1.pop_front(); busy[i] = 1'b1; wcnt[i] = cur[i].gap;
                    end
                end
                if (busy[i] && wcnt[i] == 0) begin
                    d_rd[i] = cur[i].rd; d_wr[i] = cur[i].wr; d_lock[i] = cur[i].lock;
                    d_addr[i] = cur[i].addr; d_be[i] = cur[i].be; d_data[i] = cur[i].data;
                end else begin
                    d_rd[i] = 1'b0; d_wr[i] = 1'b0; d_lock[i] = 1'b0;
                    if (busy[i]) wcnt[i]--;
                end
            end
        end
    end

    // Reference model: arbitration rules and memory image
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    int          m_last = 1;
    int          m_owner = -1;
    int          m_streak = 0;
    exp_t        sbq[$];
    int          glog[$];
    logic [31:0] last_rd [2];

    initial for (int a = 0; a < MEM_WORDS; a++) ref_mem[a] = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle grant checker; pushes expected read returns
    initial forever begin
        logic [1:0]  rq, iw, il;
        logic [11:0] ia [2];
        logic [3:0]  ib [2];
        logic [31:0] id [2];
        int          w, aw;
        exp_t        e;
        @(negedge clk);
        chk("clken", bus.mem_clken, 1);
        if (reset) begin
            chk("rst_ctrl", {bus.r0_waitrequest, bus.r1_waitrequest, bus.mem_chipselect, bus.mem_write}, 4'b1100);
            m_last = 1; m_owner = -1; m_streak = 0;
            acc = 2'b00;
        end else begin
            rq = {bus.r1_read | bus.r1_write, bus.r0_read | bus.r0_write};
            iw = {bus.r1_write, bus.r0_write};
            il = {bus.r1_lock, bus.r0_lock};
            ia[0] = bus.r0_address; ia[1] = bus.r1_address;
            ib[0] = bus.r0_byteenable; ib[1] = bus.r1_byteenable;
            id[0] = bus.r0_writedata; id[1] = bus.r1_writedata;

            if (m_owner >= 0 && rq[m_owner] && !(m_streak >= MAXL && rq[1-m_owner])) w = m_owner;
            else if (rq == 2'b11) w = 1 - m_last;
            else if (rq[0]) w = 0;
            else if (rq[1]) w = 1;
            else w = -1;

            chk("ctrl", {bus.r0_waitrequest, bus.r1_waitrequest, bus.mem_chipselect, bus.mem_write},
                {w != 0, w != 1, w >= 0, (w >= 0) ? iw[w] : 1'b0});

            acc[0] = rq[0] & ~bus.r0_waitrequest;
            acc[1] = rq[1] & ~bus.r1_waitrequest;
            aw = !bus.r0_waitrequest ? 0 : (!bus.r1_waitrequest ? 1 : -1);
            if (aw >= 0) glog.push_back(aw);

            if (w >= 0) begin
                chk("mem_cmd", {bus.mem_address, bus.mem_byteenable, bus.mem_writedata}, {ia[w], ib[w], id[w]});
                $display("cyc %0d: grant r%0d %s addr=%03h be=%h wdata=%08h lock=%0b",
                         cyc, w, iw[w] ? "WR" : "RD", ia[w], ib[w], id[w], il[w]);
                if (iw[w]) begin
                    for (int b = 0; b < 4; b++)
                        if (ib[w][b]) ref_mem[ia[w]][8*b +: 8] = id[w][8*b +: 8];
                end else begin
                    e.owner = w; e.data = ref_mem[ia[w]]; e.cyc = cyc;
                    sbq.push_back(e);
                end
                m_last = w;
                if (il[w]) begin
                    if (m_owner != w) m_streak = 0;
                    m_owner = w;
                    if (rq[1-w] && m_streak < MAXL) m_streak++;
                end else begin
                    m_owner = -1; m_streak = 0;
                end
            end
        end
    end

    // Read-return monitor
    initial forever begin
        exp_t        e;
        logic [31:0] rdat;
        @(negedge clk);
        if (reset) begin
            chk("rst_rdv", {bus.r1_readdatavalid, bus.r0_readdatavalid}, 2'b00);
            sbq.delete();
        end else if (bus.r0_readdatavalid || bus.r1_readdatavalid) begin
            if (sbq.size() == 0) begin
                chk("spurious_rdv", {bus.r1_readdatavalid, bus.r0_readdatavalid}, 2'b00);
            end else begin
                e = sbq.pop_front();
                rdat = bus.r0_readdatavalid ? bus.r0_readdata : bus.r1_readdata;
                chk("rdv_owner", {bus.r1_readdatavalid, bus.r0_readdatavalid}, (e.owner == 0) ? 2'b01 : 2'b10);
                chk("rd_latency", cyc - e.cyc, 1);
                chk("rd_data", rdat, e.data);
                last_rd[e.owner] = rdat;
                $display("cyc %0d: return r%0d rdata=%08h", cyc, e.owner, rdat);
            end
        end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            e = sbq.pop_front();
            chk("rdv_missing", {bus.r1_readdatavalid, bus.r0_readdatavalid}, (e.owner == 0) ? 2'b01 : 2'b10);
        end
    end

    task automatic push(input int r, input logic rd, input logic wr, input logic [11:0] a,
                        input logic [3:0] be, input logic [31:0] d, input logic lk, input int gap);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.addr = a; c.be = be; c.data = d; c.lock = lk; c.gap = gap;
        if (r == 0) cq0.push_back(c);
        else cq1.push_back(c);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((cq0.size() > 0 || cq1.size() > 0 || busy != 2'b00) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= budget) chk("drain_timeout", {62'd0, busy}, 0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, same;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #2;

        // Write then read back
        push(0, 0, 1, 12'h010, 4'hF, 32'hDEADBEEF, 0, 0);
        push(0, 1, 0, 12'h010, 4'hF, 32'h0, 0, 0);
        drain(50);
        chk("wr_rd_0x010", last_rd[0], 32'hDEADBEEF);

        // Continuous reads from both requesters alternate
        push(0, 0, 1, 12'h001, 4'hF, 32'h11111111, 0, 0);
        push(1, 0, 1, 12'h002, 4'hF, 32'h22222222, 0, 0);
        for (int k = 0; k < 6; k++) begin
            push(0, 1, 0, 12'h001, 4'hF, 32'h0, 0, 0);
            push(1, 1, 0, 12'h002, 4'hF, 32'h0, 0, 0);
        end
        glog.delete();
        drain(100);
        same = 0;
        for (int k = 1; k < glog.size(); k++) if (glog[k] == glog[k-1]) same++;
        chk("alternate_same_pairs", same, 0);
        chk("alternate_grants", glog.size(), 14);
        chk("r0_rd_data", last_rd[0], 32'h11111111);
        chk("r1_rd_data", last_rd[1], 32'h22222222);

        // Leave r1 as last grantee so r0 wins the opening tie of the lock run
        push(1, 1, 0, 12'h002, 4'hF, 32'h0, 0, 0);
        drain(50);

        glog.delete();
        for (int k = 0; k < 20; k++) push(0, 0, 1, 12'h100 + 12'(k), 4'hF, 32'hC0DE0000 + k, k != 19, 0);
        push(1, 1, 0, 12'h100, 4'hF, 32'h0, 0, 0);
        drain(100);
        idx = -1;
        for (int k = 0; k < glog.size(); k++) if (idx < 0 && glog[k] == 1) idx = k;
        chk("lock_hold_grants", idx, MAXL);
        chk("lock_r1_data", last_rd[1], 32'hC0DE0000);

        // Byte lanes at the top address
        push(1, 0, 1, 12'hFFF, 4'hF, 32'h00000000, 0, 0);
        push(1, 0, 1, 12'hFFF, 4'h5, 32'hAABBCCDD, 0, 0);
        push(1, 1, 0, 12'hFFF, 4'hF, 32'h0, 0, 0);
        drain(50);
        chk("byte_lanes", last_rd[1], 32'h00BB00DD);

        // Random traffic over a small address window
        for (int a = 0; a < 8; a++) push(0, 0, 1, 12'h020 + 12'(a), 4'hF, 32'h0, 0, 0);
        drain(50);
        for (int k = 0; k < 40; k++) begin
            for (int r = 0; r < 2; r++) begin
                logic rd, wr;
                int   op;
                op = $urandom_range(0, 15);
                rd = (op < 8) || (op == 15);
                wr = (op >= 8);
                push(r, rd, wr, 12'h020 + 12'($urandom_range(0, 7)), 4'($urandom_range(1, 15)),
                     $urandom, (k != 39) && ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2));
            end
        end
        drain(1000);

        // Reset one cycle after a read grant; the return must never appear
        push(0, 1, 0, 12'h010, 4'hF, 32'h0, 0, 0);
        idx = 0;
        while (!acc[0] && idx < 50) begin
            @(negedge clk);
            #1;
            idx++;
        end
        if (idx >= 50) chk("rst_read_grant_timeout", {62'd0, acc}, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        push(0, 1, 0, 12'h001, 4'hF, 32'h0, 0, 0);
        push(1, 1, 0, 12'h002, 4'hF, 32'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        glog.delete();
        reset = 1'b0;
        drain(50);
        chk("post_rst_first", (glog.size() > 0) ? glog[0] : -1, 0);
        chk("post_rst_second", (glog.size() > 1) ? glog[1] : -1, 1);
        chk("sb_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
